// File: rtl/if_stage_unit.sv
// Instruction fetch stage with IF/ID register and a one-entry skid buffer.
// Define IF_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module if_stage_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INSTR_W-1:0] id_instr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]    pend_pc_q, pend_pc_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic                 id_valid_d;
   logic [ADDR_W-1:0]    id_pc_d;
   logic [INSTR_W-1:0]   id_instr_d;
   logic                 accept;
   logic                 issue;

   always_comb begin
      accept = (state_q == StWait) && imem_rvalid && !branch_taken;
      // A response caught by freeze parks in the skid, so no new fetch that cycle.
      issue  = !branch_taken && !skid_valid_q &&
               ((state_q == StReq) || (accept && !freeze));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StReq;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (branch_taken) begin
         // Only a still-pending response needs discarding after a redirect.
         state_d = ((state_q != StReq) && !imem_rvalid) ? StDrop : StReq;
      end else if (issue) begin
         state_d = StWait;
      end else begin
         unique case (state_q)
            StReq:          state_d = StReq;
            StWait, StDrop: if (imem_rvalid) state_d = StReq;
            default:        state_d = StReq;
         endcase
      end
   end

   always_comb begin
      imem_req  = issue && !rst;
      imem_addr = pc_q;
   end

   always_comb begin
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      id_valid_d   = id_valid;
      id_pc_d      = id_pc;
      id_instr_d   = id_instr;
      if (branch_taken) begin
         pc_d         = branch_addr;
         skid_valid_d = 1'b0;
         id_valid_d   = 1'b0;
         id_pc_d      = '0;
         id_instr_d   = '0;
      end else begin
         if (issue) begin
            pc_d      = pc_q + ADDR_W'(4);
            pend_pc_d = pc_q;
         end
         if (freeze) begin
            if (accept) begin
               skid_valid_d = 1'b1;
               skid_pc_d    = pend_pc_q + ADDR_W'(4);
               skid_instr_d = imem_rdata;
            end
         end else if (skid_valid_q) begin
            skid_valid_d = 1'b0;
            id_valid_d   = 1'b1;
            id_pc_d      = skid_pc_q;
            id_instr_d   = skid_instr_q;
         end else if (accept) begin
            id_valid_d = 1'b1;
            id_pc_d    = pend_pc_q + ADDR_W'(4);
            id_instr_d = imem_rdata;
         end else begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         pend_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         id_valid     <= 1'b0;
         id_pc        <= '0;
         id_instr     <= '0;
      end else begin
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         id_valid     <= id_valid_d;
         id_pc        <= id_pc_d;
         id_instr     <= id_instr_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (freeze && (skid_valid_q || id_valid) && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (branch_taken && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Bench for if_stage_unit: directed scenarios then random freeze/branch/latency traffic,
// checked against a transaction-level model of the fetch stage.
module tb_if_stage_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   if_stage_unit #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_instr     (id_instr)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Memory environment: one responder, fixed latency per request.
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   logic        obs_req;
   logic [31:0] obs_addr;

   // Transaction-level model: the one in-flight fetch (possibly dead), skid slot, IF/ID slot.
   logic [31:0] m_pc = '0;
   logic        m_fly = 1'b0;
   logic        m_dead = 1'b0;
   logic [31:0] m_fly_addr = '0;
   logic        m_skid_v = 1'b0;
   logic [31:0] m_skid_pc = '0;
   logic [31:0] m_skid_instr = '0;
   logic        m_id_v = 1'b0;
   logic [31:0] m_id_pc = '0;
   logic [31:0] m_id_instr = '0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      if (a == 32'h8) return 32'hE3A0_1005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit fz, input bit br, input logic [31:0] ba, input int lat,
                       input bit rs, input bit junk);
      logic        rv;
      logic [31:0] rd;
      logic        live;
      logic        exp_req;
      @(negedge clk);
      rv = 1'b0;
      rd = $urandom;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            rv = 1'b1;
            rd = instr_of(mem_addr);
         end
      end else if (junk && !m_fly) begin
         rv = 1'b1;
      end
      rst          = rs;
      freeze       = fz;
      branch_taken = br;
      branch_addr  = ba;
      imem_rvalid  = rv;
      imem_rdata   = rd;
      #1;
      live    = m_fly && !m_dead && rv && !br;
      exp_req = !rs && !br && !m_skid_v && (!m_fly || (live && !fz));
      obs_req  = imem_req;
      obs_addr = imem_addr;
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      if (rs) begin
         check("rst_id_valid", {31'b0, id_valid}, 32'h0);
         check("rst_id_pc", id_pc, 32'h0);
         check("rst_id_instr", id_instr, 32'h0);
      end
      if (rs) begin
         m_pc = '0; m_fly = 1'b0; m_dead = 1'b0; m_skid_v = 1'b0;
         m_id_v = 1'b0; m_id_pc = '0; m_id_instr = '0; m_stall = '0; m_flush = '0;
      end else begin
         if (fz && (m_skid_v || m_id_v) && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (br && m_flush != 32'hFFFF_FFFF) m_flush++;
         if (br) begin
            m_pc = ba;
            m_id_v = 1'b0; m_id_pc = '0; m_id_instr = '0; m_skid_v = 1'b0;
            m_fly = m_fly && !rv;
            m_dead = 1'b1;
         end else begin
            if (fz) begin
               if (live) begin
                  m_skid_v = 1'b1; m_skid_pc = m_fly_addr + 32'd4; m_skid_instr = rd;
               end
            end else if (m_skid_v) begin
               m_id_v = 1'b1; m_id_pc = m_skid_pc; m_id_instr = m_skid_instr; m_skid_v = 1'b0;
            end else if (live) begin
               m_id_v = 1'b1; m_id_pc = m_fly_addr + 32'd4; m_id_instr = rd;
            end else begin
               m_id_v = 1'b0; m_id_instr = '0;
            end
            if (exp_req) begin
               m_fly = 1'b1; m_dead = 1'b0; m_fly_addr = m_pc; m_pc = m_pc + 32'd4;
            end else if (rv) begin
               m_fly = 1'b0;
            end
         end
      end
      @(posedge clk);
      if (obs_req) begin
         mem_cnt  = lat;
         mem_addr = obs_addr;
      end
      #1;
      check("id_valid", {31'b0, id_valid}, {31'b0, m_id_v});
      check("id_instr", id_instr, m_id_instr);
      if (m_id_v) check("id_pc", id_pc, m_id_pc);
`ifdef IF_PERF_CNT_EN
      check("perf_stall_cnt", perf_stall_cnt, m_stall);
      check("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif
   endtask

   initial begin
      // Reset held: outputs zero, no request.
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      // Back-to-back fetch with 1-cycle memory.
      step(0, 0, 0, 1, 0, 0);
      check("seq_req0", {31'b0, obs_req}, 32'h1);
      check("seq_addr0", obs_addr, 32'h0);
      step(0, 0, 0, 1, 0, 0);
      check("seq_addr4", obs_addr, 32'h4);
      check("seq_id_pc4", id_pc, 32'h4);
      step(0, 0, 0, 1, 0, 0);
      check("seq_addr8", obs_addr, 32'h8);
      check("seq_id_pc8", id_pc, 32'h8);
      // Freeze while the response for address 8 lands.
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 1, 0, 0);
         check("frz_no_req", {31'b0, obs_req}, 32'h0);
         check("frz_hold_pc", id_pc, 32'h8);
      end
      step(0, 0, 0, 1, 0, 0);
      check("skid_instr", id_instr, 32'hE3A0_1005);
      check("skid_pc", id_pc, 32'hC);
      // Redirect while a slow fetch of 0x10 is outstanding.
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 3, 0, 0);
      check("slow_addr", obs_addr, 32'h10);
      step(0, 1, 32'h40, 1, 0, 0);
      check("br_no_req", {31'b0, obs_req}, 32'h0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      check("drop_no_req", {31'b0, obs_req}, 32'h0);
      check("drop_not_valid", {31'b0, id_valid}, 32'h0);
      step(0, 0, 0, 1, 0, 0);
      check("redir_addr", obs_addr, 32'h40);
      step(0, 0, 0, 1, 0, 0);
      check("redir_id_pc", id_pc, 32'h44);
      // Branch overrides freeze.
      step(1, 1, 32'h80, 1, 0, 0);
      check("brfz_valid", {31'b0, id_valid}, 32'h0);
      check("brfz_pc", imem_addr, 32'h80);
      // Reset during an outstanding fetch; its late response must be ignored.
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 3, 0, 0);
      check("pre_rst_valid", {31'b0, id_valid}, 32'h1);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      check("post_rst_addr", obs_addr, 32'h0);
      check("post_rst_bubble", {31'b0, id_valid}, 32'h0);
      step(0, 0, 0, 1, 0, 0);
      check("post_rst_id_pc", id_pc, 32'h4);
      // Two flushes and five freeze-stall cycles from a fresh reset.
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0);
      step(0, 1, 32'h100, 1, 0, 0);
      step(0, 1, 32'h200, 1, 0, 0);
`ifdef IF_PERF_CNT_EN
      check("perf_flush_2", perf_flush_cnt, 32'd2);
      check("perf_stall_5", perf_stall_cnt, 32'd5);
`endif
      // Random traffic, including redirects near the top of the address space.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ba;
         ba = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
         step((($urandom % 4) == 0), (($urandom % 12) == 0), ba, 1 + int'($urandom % 3),
              (($urandom % 300) == 0), (($urandom % 16) == 0));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
